jk_ff_bank: RTL and testbench
=============================

# jk_ff_bank

Parametrised bank of WIDTH JK-style storage bits, the next generation of the single-bit `jk_ff`. Adds a per-bank mode select (JK, T, D, SR), clock enable, synchronous clear, and registered change-tracking outputs: a per-bit change mask, a saturating change counter and a sticky SR-illegal flag. It sits wherever the single-bit `jk_ff` sat and is driven through the same interface-style bench with a `j`/`k`/`q` naming scheme.

## Interface
- `WIDTH`, 8: number of storage bits; legal range 1..64.
- `CNT_W`, 16: width of `chg_cnt`; must be ≥ clog2(WIDTH+1).
- `RESET_VAL`, '0: WIDTH-bit value loaded into `q` on reset and on `sync_clr`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  clock enable for `q` updates.
- `sync_clr`  in  1  synchronous clear; has priority over `en`.
- `mode`  in  2  00 JK, 01 T, 10 D, 11 SR.
- `j`  in  WIDTH  J / T / D / S input per bit, depending on `mode`.
- `k`  in  WIDTH  K / R input per bit; ignored in T and D modes.
- `q`  out  WIDTH  stored value.
- `qn`  out  WIDTH  combinational ~`q`.
- `chg`  out  WIDTH  bits of `q` that changed on the last edge.
- `chg_cnt`  out  CNT_W  running total of bit changes; saturates at all-ones.
- `sr_err`  out  1  sticky flag: an illegal SR combination was applied.

## Operation
- Next-state per bit i, used only when `en`=1 and `sync_clr`=0:
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - T: `j[i]`=1 toggles, 0 holds.
  - D: `q[i]` <= `j[i]`.
  - SR: 10 set, 01 clear, 00 hold. 11 is illegal: that bit holds and `sr_err` is set.
- `mode` is decoded combinationally. A change of mode takes effect at the next edge; it carries no history and needs no drain cycle.
- Enabled edge:
  - `chg` <= q_next ^ q.
  - `chg_cnt` <= min(`chg_cnt` + popcount(q_next ^ q), 2^CNT_W − 1). The sum is computed at CNT_W+1 bits, then clamped.
- `en`=0 and `sync_clr`=0:
  - `q` holds.
  - `chg` <= 0.
  - `chg_cnt` and `sr_err` hold.
  - An SR 11 pattern while `en`=0 does not set `sr_err`.
- `sync_clr`=1, whatever `en` is:
  - `q` <= RESET_VAL.
  - `chg` <= 0, `chg_cnt` <= 0, `sr_err` <= 0.
  - The clear is not counted as a change.
- `sr_err`:
  - Set at the edge where `en`=1, `mode`=11 and (j & k) ≠ 0.
  - Cleared only by `sync_clr` or `rst_n`.
  - If set and clear conditions meet on the same edge, the clear wins.
- Saturation: once `chg_cnt` reaches all-ones it stays there until cleared. It never wraps.

## Timing
- Reset (`rst_n` low, asynchronous): `q`=RESET_VAL, `qn`=~RESET_VAL, `chg`=0, `chg_cnt`=0, `sr_err`=0. Outputs take these values immediately, without waiting for `clk`.
- Reset release is synchronous: the first edge with `rst_n`=1 performs a normal update.
- Reset asserted mid-operation overrides any in-progress sequence. No state survives.
- Latency:
  - `q`, `chg`, `chg_cnt`, `sr_err`: 1 cycle from the sampled inputs.
  - `qn`: 0 cycles from `q`.
- All outputs except `qn` are registered. There is no combinational path from inputs to outputs.
- `j`, `k`, `mode`, `en` and `sync_clr` are sampled only at the rising edge of `clk`.

## Test plan
- Reset and hold (WIDTH=8, RESET_VAL=8'hA5):
  - Stimulus: assert `rst_n` low between edges, then release with `en`=0.
  - Response: `q`=A5 and `qn`=5A immediately. After 3 edges `q`=A5, `chg`=0, `chg_cnt`=0.
- JK truth table:
  - Stimulus: `q`=00, `mode`=00, `en`=1. Apply j=F0,k=00; then j=0F,k=0F; then j=FF,k=FF.
  - Response: `q` goes F0, then FF, then 00.
  - `chg` follows F0, 0F, FF. `chg_cnt` follows 4, 8, 16.
- T and D modes:
  - Stimulus: from `q`=00, `mode`=01, j=81 for 2 edges. Then `mode`=10, j=3C.
  - Response: `q` goes 81, 00, 3C. `chg_cnt` ends at 2+2+4=8.
- SR illegal:
  - Stimulus: `mode`=11, `q`=00, j=03,k=01 for 1 edge.
  - Response: `q`=02 (bit0 held), `sr_err`=1.
  - `sr_err` stays 1 through later legal cycles and clears one edge after `sync_clr`=1.
- Enable and clear priority:
  - Stimulus: `en`=0 with JK toggle-all → `q` unchanged, `chg`=0. Then `sync_clr`=1 together with `en`=1 and toggle-all.
  - Response: `q`=RESET_VAL, counters 0.
- Saturation (CNT_W=4, WIDTH=8):
  - Stimulus: JK toggle-all for 2 edges.
  - Response: `chg_cnt` goes 8, then 15, and stays 15 on the 3rd edge.
- Async reset mid-run:
  - Stimulus: drive `rst_n` low between edges while toggling.
  - Response: all outputs return to reset values at once.

Source files
------------

// File: rtl/jk_ff_bank.sv
`default_nettype none
//==============================================================================
// Module      : jk_ff_bank
// Description : Bank of WIDTH storage bits with a per-bank mode select
//               (JK, T, D, SR), clock enable and synchronous clear, plus
//               registered change tracking: per-bit change mask, saturating
//               change counter and a sticky SR-illegal flag.
//
// Ports       : clk       rising-edge clock
//               rst_n     asynchronous active-low reset
//               en        clock enable for q updates
//               sync_clr  synchronous clear (priority over en)
//               mode      00 JK, 01 T, 10 D, 11 SR
//               j         J / T / D / S input per bit
//               k         K / R input per bit (ignored in T and D modes)
//               q         stored value
//               qn        combinational ~q
//               chg       bits of q that changed on the last edge
//               chg_cnt   saturating running total of bit changes
//               sr_err    sticky illegal-SR flag
//
// Revision    : 1.0 - initial release
//==============================================================================
module jk_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] chg,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [1:0] c_MODE_JK = 2'b00;
    localparam logic [1:0] c_MODE_T  = 2'b01;
    localparam logic [1:0] c_MODE_D  = 2'b10;
    localparam logic [1:0] c_MODE_SR = 2'b11;

    // Enough bits to hold a popcount of WIDTH ones.
    localparam int c_POP_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_chg;
    logic [CNT_W-1:0]   r_chg_cnt;
    logic               r_sr_err;

    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_diff;
    logic [c_POP_W-1:0] w_pop;
    logic [CNT_W:0]     w_sum;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_sr_illegal;

    //--------------------------------------------------------------------------
    // Per-bit next-state decode
    //--------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_nxt;

        always_comb begin
            w_nxt = r_q[i];
            case (mode)
                c_MODE_JK: begin
                    case ({j[i], k[i]})
                        2'b01:   w_nxt = 1'b0;
                        2'b10:   w_nxt = 1'b1;
                        2'b11:   w_nxt = ~r_q[i];
                        default: w_nxt = r_q[i];
                    endcase
                end
                c_MODE_T: begin
                    w_nxt = j[i] ? ~r_q[i] : r_q[i];
                end
                c_MODE_D: begin
                    w_nxt = j[i];
                end
                c_MODE_SR: begin
                    // 11 is illegal and simply holds; the flag is raised below.
                    case ({j[i], k[i]})
                        2'b01:   w_nxt = 1'b0;
                        2'b10:   w_nxt = 1'b1;
                        default: w_nxt = r_q[i];
                    endcase
                end
                default: w_nxt = r_q[i];
            endcase
        end

        assign w_q_next[i] = w_nxt;
    end

    assign w_diff       = w_q_next ^ r_q;
    assign w_sr_illegal = (mode == c_MODE_SR) && (|(j & k));

    //--------------------------------------------------------------------------
    // Change counter: popcount of toggled bits, added one bit wider than the
    // counter so the carry-out flags overflow, then clamped to all-ones.
    //--------------------------------------------------------------------------
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + c_POP_W'(w_diff[i]);
        end
    end

    assign w_sum      = {1'b0, r_chg_cnt} + (CNT_W + 1)'(w_pop);
    assign w_cnt_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= RESET_VAL;
            r_chg     <= '0;
            r_chg_cnt <= '0;
            r_sr_err  <= 1'b0;
        end else if (sync_clr) begin
            // The clear is not a counted change and overrides any SR error
            // raised on the same edge.
            r_q       <= RESET_VAL;
            r_chg     <= '0;
            r_chg_cnt <= '0;
            r_sr_err  <= 1'b0;
        end else if (en) begin
            r_q       <= w_q_next;
            r_chg     <= w_diff;
            r_chg_cnt <= w_cnt_next;
            if (w_sr_illegal) begin
                r_sr_err <= 1'b1;
            end
        end else begin
            // Disabled edge: nothing changed, so the mask drops to zero.
            r_chg <= '0;
        end
    end

    assign q       = r_q;
    assign qn      = ~r_q;
    assign chg     = r_chg;
    assign chg_cnt = r_chg_cnt;
    assign sr_err  = r_sr_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_ff_bank.sv
`default_nettype none
//==============================================================================
// Module      : tb_jk_ff_bank
// Description : Directed self-checking bench for jk_ff_bank. A main instance
//               (WIDTH=8, CNT_W=16, RESET_VAL=A5) and a narrow-counter
//               instance (CNT_W=4) share all stimulus.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_jk_ff_bank;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        en       = 1'b0;
    logic        sync_clr = 1'b0;
    logic [1:0]  mode     = 2'b00;
    logic [7:0]  j        = 8'h00;
    logic [7:0]  k        = 8'h00;

    logic [7:0]  q, qn, chg;
    logic [15:0] chg_cnt;
    logic        sr_err;

    logic [7:0]  q_s, qn_s, chg_s;
    logic [3:0]  chg_cnt_s;
    logic        sr_err_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    jk_ff_bank #(.WIDTH(8), .CNT_W(16), .RESET_VAL(8'hA5)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .mode(mode),
        .j(j), .k(k), .q(q), .qn(qn), .chg(chg), .chg_cnt(chg_cnt), .sr_err(sr_err)
    );

    jk_ff_bank #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'hA5)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .mode(mode),
        .j(j), .k(k), .q(q_s), .qn(qn_s), .chg(chg_s), .chg_cnt(chg_cnt_s),
        .sr_err(sr_err_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({q, qn} !== {8'hA5, 8'h5A})
            $display("FAIL reset_immediate: got q=%h qn=%h, want q=a5 qn=5a", q, qn);
        else n_pass++;
        n_total++;
        if ({chg, chg_cnt, sr_err, chg_cnt_s} !== {8'h00, 16'd0, 1'b0, 4'd0})
            $display("FAIL reset_tracking: got chg=%h cnt=%0d err=%b cnt_s=%0d, want 0 0 0 0",
                     chg, chg_cnt, sr_err, chg_cnt_s);
        else n_pass++;
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        n_total++;
        if ({q, chg, chg_cnt, sr_err} !== {8'hA5, 8'h00, 16'd0, 1'b0})
            $display("FAIL reset_hold: got q=%h chg=%h cnt=%0d err=%b, want a5 00 0 0",
                     q, chg, chg_cnt, sr_err);
        else n_pass++;
    endtask

    task automatic test_jk();
        // D-load zero from A5: four bits change.
        en = 1'b1; mode = 2'b10; j = 8'h00; k = 8'h00;
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'h00, 8'hA5, 16'd4})
            $display("FAIL jk_preload: got q=%h chg=%h cnt=%0d, want 00 a5 4", q, chg, chg_cnt);
        else n_pass++;
        mode = 2'b00; j = 8'hF0; k = 8'h00;
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'hF0, 8'hF0, 16'd8})
            $display("FAIL jk_set: got q=%h chg=%h cnt=%0d, want f0 f0 8", q, chg, chg_cnt);
        else n_pass++;
        j = 8'h0F; k = 8'h0F;
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'hFF, 8'h0F, 16'd12})
            $display("FAIL jk_toggle_low: got q=%h chg=%h cnt=%0d, want ff 0f 12", q, chg, chg_cnt);
        else n_pass++;
        j = 8'hFF; k = 8'hFF;
        tick();
        n_total++;
        if ({q, qn, chg, chg_cnt} !== {8'h00, 8'hFF, 8'hFF, 16'd20})
            $display("FAIL jk_toggle_all: got q=%h qn=%h chg=%h cnt=%0d, want 00 ff ff 20",
                     q, qn, chg, chg_cnt);
        else n_pass++;
        // JK clear on already-zero bits: nothing moves.
        j = 8'h00; k = 8'hFF;
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'h00, 8'h00, 16'd20})
            $display("FAIL jk_clear: got q=%h chg=%h cnt=%0d, want 00 00 20", q, chg, chg_cnt);
        else n_pass++;
    endtask

    task automatic test_t_d();
        mode = 2'b01; j = 8'h81; k = 8'hFF;
        tick();
        n_total++;
        if ({q, chg_cnt} !== {8'h81, 16'd22})
            $display("FAIL t_first: got q=%h cnt=%0d, want 81 22", q, chg_cnt);
        else n_pass++;
        tick();
        n_total++;
        if ({q, chg_cnt} !== {8'h00, 16'd24})
            $display("FAIL t_second: got q=%h cnt=%0d, want 00 24", q, chg_cnt);
        else n_pass++;
        mode = 2'b10; j = 8'h3C; k = 8'hFF;
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'h3C, 8'h3C, 16'd28})
            $display("FAIL d_load: got q=%h chg=%h cnt=%0d, want 3c 3c 28", q, chg, chg_cnt);
        else n_pass++;
    endtask

    task automatic test_sr_illegal();
        mode = 2'b10; j = 8'h00; k = 8'h00;
        tick();
        n_total++;
        if ({q, chg_cnt, sr_err} !== {8'h00, 16'd32, 1'b0})
            $display("FAIL sr_pre: got q=%h cnt=%0d err=%b, want 00 32 0", q, chg_cnt, sr_err);
        else n_pass++;
        mode = 2'b11; j = 8'h03; k = 8'h01;
        tick();
        n_total++;
        if ({q, chg, chg_cnt, sr_err} !== {8'h02, 8'h02, 16'd33, 1'b1})
            $display("FAIL sr_illegal: got q=%h chg=%h cnt=%0d err=%b, want 02 02 33 1",
                     q, chg, chg_cnt, sr_err);
        else n_pass++;
        j = 8'h00; k = 8'h02;
        tick();
        n_total++;
        if ({q, chg, sr_err} !== {8'h00, 8'h02, 1'b1})
            $display("FAIL sr_sticky: got q=%h chg=%h err=%b, want 00 02 1", q, chg, sr_err);
        else n_pass++;
        sync_clr = 1'b1; j = 8'h01; k = 8'h01;   // illegal too, clear must win
        tick();
        n_total++;
        if ({q, chg, chg_cnt, sr_err} !== {8'hA5, 8'h00, 16'd0, 1'b0})
            $display("FAIL sr_clear: got q=%h chg=%h cnt=%0d err=%b, want a5 00 0 0",
                     q, chg, chg_cnt, sr_err);
        else n_pass++;
        sync_clr = 1'b0; en = 1'b0; j = 8'hFF; k = 8'hFF;
        tick();
        n_total++;
        if ({q, chg, chg_cnt, sr_err} !== {8'hA5, 8'h00, 16'd0, 1'b0})
            $display("FAIL sr_disabled: got q=%h chg=%h cnt=%0d err=%b, want a5 00 0 0",
                     q, chg, chg_cnt, sr_err);
        else n_pass++;
    endtask

    task automatic test_enable_clear();
        en = 1'b1; mode = 2'b00; j = 8'hFF; k = 8'hFF;
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'h5A, 8'hFF, 16'd8})
            $display("FAIL en_toggle: got q=%h chg=%h cnt=%0d, want 5a ff 8", q, chg, chg_cnt);
        else n_pass++;
        en = 1'b0;
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'h5A, 8'h00, 16'd8})
            $display("FAIL en_hold: got q=%h chg=%h cnt=%0d, want 5a 00 8", q, chg, chg_cnt);
        else n_pass++;
        en = 1'b1; sync_clr = 1'b1;
        tick();
        n_total++;
        if ({q, chg, chg_cnt, sr_err, chg_cnt_s} !== {8'hA5, 8'h00, 16'd0, 1'b0, 4'd0})
            $display("FAIL clr_priority: got q=%h chg=%h cnt=%0d err=%b cnt_s=%0d, want a5 00 0 0 0",
                     q, chg, chg_cnt, sr_err, chg_cnt_s);
        else n_pass++;
        sync_clr = 1'b0;
    endtask

    task automatic test_saturation();
        en = 1'b1; mode = 2'b00; j = 8'hFF; k = 8'hFF;
        tick();
        n_total++;
        if ({chg_cnt_s, chg_cnt} !== {4'd8, 16'd8})
            $display("FAIL sat_first: got cnt_s=%0d cnt=%0d, want 8 8", chg_cnt_s, chg_cnt);
        else n_pass++;
        tick();
        n_total++;
        if ({chg_cnt_s, chg_cnt, q_s} !== {4'd15, 16'd16, 8'hA5})
            $display("FAIL sat_clamp: got cnt_s=%0d cnt=%0d q_s=%h, want 15 16 a5",
                     chg_cnt_s, chg_cnt, q_s);
        else n_pass++;
        tick();
        n_total++;
        if ({chg_cnt_s, chg_cnt} !== {4'd15, 16'd24})
            $display("FAIL sat_hold: got cnt_s=%0d cnt=%0d, want 15 24", chg_cnt_s, chg_cnt);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        // q is 5A here; raise sr_err with bit0 (held at 0).
        mode = 2'b11; j = 8'h01; k = 8'h01;
        tick();
        n_total++;
        if ({q, sr_err} !== {8'h5A, 1'b1})
            $display("FAIL ar_setup: got q=%h err=%b, want 5a 1", q, sr_err);
        else n_pass++;
        mode = 2'b00; j = 8'hFF; k = 8'hFF;
        tick();
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'h5A, 8'hFF, 16'd40})
            $display("FAIL ar_running: got q=%h chg=%h cnt=%0d, want 5a ff 40", q, chg, chg_cnt);
        else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({q, qn, chg, chg_cnt, sr_err, chg_cnt_s} !==
            {8'hA5, 8'h5A, 8'h00, 16'd0, 1'b0, 4'd0})
            $display("FAIL ar_immediate: got q=%h qn=%h chg=%h cnt=%0d err=%b cnt_s=%0d, want a5 5a 00 0 0 0",
                     q, qn, chg, chg_cnt, sr_err, chg_cnt_s);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_total++;
        if ({q, chg, chg_cnt} !== {8'h5A, 8'hFF, 16'd8})
            $display("FAIL ar_release: got q=%h chg=%h cnt=%0d, want 5a ff 8", q, chg, chg_cnt);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_jk();
        test_t_d();
        test_sr_illegal();
        test_enable_clear();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
